// File: rtl/tour_cmd.sv
`default_nettype none
// ============================================================================
//  Module      : tour_cmd
//  Description : Consumer-side sequencer for the knight's-tour solver. After
//                a tour is solved it reads the one-hot moves back by index
//                and turns each L-shaped move into two straight-line motion
//                commands: a vertical leg, then a horizontal leg with
//                fanfare. Each command uses the cmd_rdy/clr_cmd_rdy handshake
//                and is paced by send_resp. Outside a tour the block is a
//                transparent mux for UART commands.
//
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                start_tour           - pulse, begins readout of a solved tour
//                move[7:0]            - one-hot move at indx (from solver)
//                indx[4:0]            - index of the move being read
//                cmd_UART[15:0]       - UART-side command
//                cmd_rdy_UART         - UART command valid
//                clr_cmd_rdy_UART     - UART command consumed
//                cmd[15:0], cmd_rdy   - command and valid to the consumer
//                clr_cmd_rdy          - consumer has taken cmd
//                send_resp            - motion leg complete
//                resp[7:0]            - response byte
//                tour_busy            - high whenever not IDLE
//                tour_err             - sticky illegal-move flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tour_cmd #(
    parameter int         NUM_MOVES = 24,
    parameter logic [7:0] POS_ACK   = 8'hA5,
    parameter logic [7:0] MID_ACK   = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        tour_busy,
    output logic        tour_err
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_VERT  = 3'd1;
    localparam logic [2:0] c_HOLDV = 3'd2;
    localparam logic [2:0] c_HORZ  = 3'd3;
    localparam logic [2:0] c_HOLDH = 3'd4;

    localparam logic [4:0] c_LAST_INDX = 5'(NUM_MOVES - 1);

    // Opcodes and headings
    localparam logic [3:0] c_OP_MOVE = 4'h2;
    localparam logic [3:0] c_OP_FANF = 4'h3;
    localparam logic [7:0] c_NORTH   = 8'h00;
    localparam logic [7:0] c_WEST    = 8'h3F;
    localparam logic [7:0] c_SOUTH   = 8'h7F;
    localparam logic [7:0] c_EAST    = 8'hBF;

    logic [2:0]  r_state;
    logic [4:0]  r_indx;
    logic        r_tour_err;

    logic [2:0]  w_state_nxt;
    logic [4:0]  w_indx_nxt;
    logic        w_err_nxt;

    logic        w_one_hot;
    logic [15:0] w_vert_cmd;
    logic [15:0] w_horz_cmd;
    logic        w_last;

    // ------------------------------------------------------------------
    // Move decode. Only the eight exact one-hot codes are legal; any other
    // value (zero or multi-hot) clears w_one_hot and yields null commands.
    // ------------------------------------------------------------------
    always_comb begin
        w_one_hot  = 1'b1;
        w_vert_cmd = 16'h0000;
        w_horz_cmd = 16'h0000;
        case (move)
            8'h01: begin // (-1,+2)
                w_vert_cmd = {c_OP_MOVE, c_NORTH, 4'd2};
                w_horz_cmd = {c_OP_FANF, c_WEST,  4'd1};
            end
            8'h02: begin // (+1,+2)
                w_vert_cmd = {c_OP_MOVE, c_NORTH, 4'd2};
                w_horz_cmd = {c_OP_FANF, c_EAST,  4'd1};
            end
            8'h04: begin // (-2,+1)
                w_vert_cmd = {c_OP_MOVE, c_NORTH, 4'd1};
                w_horz_cmd = {c_OP_FANF, c_WEST,  4'd2};
            end
            8'h08: begin // (-2,-1)
                w_vert_cmd = {c_OP_MOVE, c_SOUTH, 4'd1};
                w_horz_cmd = {c_OP_FANF, c_WEST,  4'd2};
            end
            8'h10: begin // (-1,-2)
                w_vert_cmd = {c_OP_MOVE, c_SOUTH, 4'd2};
                w_horz_cmd = {c_OP_FANF, c_WEST,  4'd1};
            end
            8'h20: begin // (+1,-2)
                w_vert_cmd = {c_OP_MOVE, c_SOUTH, 4'd2};
                w_horz_cmd = {c_OP_FANF, c_EAST,  4'd1};
            end
            8'h40: begin // (+2,+1)
                w_vert_cmd = {c_OP_MOVE, c_NORTH, 4'd1};
                w_horz_cmd = {c_OP_FANF, c_EAST,  4'd2};
            end
            8'h80: begin // (+2,-1)
                w_vert_cmd = {c_OP_MOVE, c_SOUTH, 4'd1};
                w_horz_cmd = {c_OP_FANF, c_EAST,  4'd2};
            end
            default: w_one_hot = 1'b0;
        endcase
    end

    assign w_last = (r_indx == c_LAST_INDX);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_indx_nxt  = r_indx;
        w_err_nxt   = r_tour_err;
        case (r_state)
            c_IDLE: begin
                if (start_tour) begin
                    w_state_nxt = c_VERT;
                    w_indx_nxt  = 5'd0;
                    w_err_nxt   = 1'b0;
                end
            end
            c_VERT: begin
                // An illegal move aborts the tour before any handshake.
                if (!w_one_hot) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_IDLE;
                end else if (clr_cmd_rdy) begin
                    w_state_nxt = c_HOLDV;
                end
            end
            c_HOLDV: begin
                if (send_resp) w_state_nxt = c_HORZ;
            end
            c_HORZ: begin
                if (clr_cmd_rdy) w_state_nxt = c_HOLDH;
            end
            c_HOLDH: begin
                if (send_resp) begin
                    if (w_last) begin
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_indx_nxt  = r_indx + 5'd1;
                        w_state_nxt = c_VERT;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_indx     <= 5'd0;
            r_tour_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_indx     <= w_indx_nxt;
            r_tour_err <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output mux: UART pass-through in IDLE, sequencer otherwise.
    // ------------------------------------------------------------------
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        case (r_state)
            c_IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
            end
            c_VERT: begin
                cmd     = w_vert_cmd;
                cmd_rdy = w_one_hot;
            end
            c_HOLDV: begin
                cmd = w_vert_cmd;
            end
            c_HORZ: begin
                cmd     = w_horz_cmd;
                cmd_rdy = 1'b1;
            end
            c_HOLDH: begin
                cmd = w_horz_cmd;
            end
            default: begin
                cmd = cmd_UART;
            end
        endcase
    end

    assign resp      = ((r_state == c_IDLE) || ((r_state == c_HOLDH) && w_last))
                       ? POS_ACK : MID_ACK;
    assign tour_busy = (r_state != c_IDLE);
    assign tour_err  = r_tour_err;
    assign indx      = r_indx;

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tour_cmd
//  Description : Directed self-checking bench for tour_cmd. A small move
//                memory stands in for the solver; the bench acts as the
//                command consumer and motion controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tour_cmd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;
    logic        tour_busy;
    logic        tour_err;

    logic [7:0]  moves [0:31];
    int          errors = 0;
    int          checks = 0;
    int          n_cmds = 0;
    int          base_cmds;

    always #5 clk = ~clk;

    assign move = moves[indx];

    tour_cmd dut (
        .clk              (clk),
        .rst              (rst),
        .start_tour       (start_tour),
        .move             (move),
        .indx             (indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp),
        .tour_busy        (tour_busy),
        .tour_err         (tour_err)
    );

    // Count accepted sequencer commands (valid and taken on the same edge).
    always @(posedge clk) begin
        if (tour_busy && cmd_rdy && clr_cmd_rdy) n_cmds <= n_cmds + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for cmd_rdy, check the command, then take it after dly cycles.
    task automatic handshake(input string tag, input logic [15:0] exp_cmd,
                             input int dly, input logic [7:0] exp_hold_resp);
        for (int k = 0; k < 20 && !cmd_rdy; k++) step();
        chk({tag, " cmd_rdy"}, 32'(cmd_rdy), 32'd1);
        chk({tag, " cmd"}, 32'(cmd), 32'(exp_cmd));
        repeat (dly) step();
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        chk({tag, " hold cmd_rdy"}, 32'(cmd_rdy), 32'd0);
        chk({tag, " hold resp"}, 32'(resp), 32'(exp_hold_resp));
    endtask

    task automatic respond(input int dly);
        repeat (dly) step();
        send_resp = 1'b1;
        step();
        send_resp = 1'b0;
    endtask

    task automatic run_move(input int idx, input logic [15:0] v, input logic [15:0] h);
        handshake("vert", v, int'($urandom_range(0, 3)), 8'h5A);
        respond(int'($urandom_range(0, 3)));
        handshake("horz", h, int'($urandom_range(0, 3)), (idx == 23) ? 8'hA5 : 8'h5A);
        respond(int'($urandom_range(0, 3)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) moves[i] = 8'h01;
        moves[1] = 8'h80;
        moves[2] = 8'h04;

        // Reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst busy", 32'(tour_busy), 32'd0);
        chk("rst indx", 32'(indx), 32'd0);
        chk("rst err", 32'(tour_err), 32'd0);
        chk("rst resp", 32'(resp), 32'hA5);

        // UART pass-through in IDLE
        cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
        #1;
        chk("uart cmd", 32'(cmd), 32'h1234);
        chk("uart cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("uart clr", 32'(clr_cmd_rdy_UART), 32'd1);
        chk("uart resp", 32'(resp), 32'hA5);
        clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
        #1;
        chk("uart clr low", 32'(clr_cmd_rdy_UART), 32'd0);

        // Tour A: full 24 moves
        base_cmds = n_cmds;
        start_tour = 1'b1;
        step();
        start_tour = 1'b0;
        chk("A0 vert cmd", 32'(cmd), 32'h2002);
        chk("A0 vert rdy", 32'(cmd_rdy), 32'd1);
        chk("A0 busy", 32'(tour_busy), 32'd1);
        chk("A0 resp", 32'(resp), 32'h5A);
        clr_cmd_rdy = 1'b1; send_resp = 1'b1;
        #1;
        chk("A0 clr_uart blocked", 32'(clr_cmd_rdy_UART), 32'd0);
        step();   // clr and send_resp together: only clr honoured
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        chk("A0 holdv rdy", 32'(cmd_rdy), 32'd0);
        chk("A0 holdv cmd", 32'(cmd), 32'h2002);
        clr_cmd_rdy = 1'b1; start_tour = 1'b1;
        step();   // both ignored in HOLDV
        clr_cmd_rdy = 1'b0; start_tour = 1'b0;
        chk("A0 holdv stays", 32'(cmd_rdy), 32'd0);
        chk("A0 holdv indx", 32'(indx), 32'd0);
        send_resp = 1'b1;
        step();
        chk("A0 horz cmd", 32'(cmd), 32'h33F1);
        chk("A0 horz rdy", 32'(cmd_rdy), 32'd1);
        step();   // send_resp ignored in HORZ
        send_resp = 1'b0;
        chk("A0 horz stays", 32'(cmd_rdy), 32'd1);
        handshake("A0 horz", 16'h33F1, 0, 8'h5A);
        respond(0);
        chk("A1 indx", 32'(indx), 32'd1);
        chk("A1 resp", 32'(resp), 32'h5A);
        run_move(1, 16'h27F1, 16'h3BF2);
        run_move(2, 16'h2001, 16'h33F2);
        for (int i = 3; i < 24; i++) run_move(i, 16'h2002, 16'h33F1);
        chk("A end busy", 32'(tour_busy), 32'd0);
        chk("A end indx", 32'(indx), 32'd23);
        chk("A end resp", 32'(resp), 32'hA5);
        chk("A cmd count", 32'(n_cmds - base_cmds), 32'd48);

        // Tour B: illegal move at index 5
        moves[1] = 8'h01; moves[2] = 8'h01; moves[5] = 8'h03;
        start_tour = 1'b1;
        step();
        start_tour = 1'b0;
        for (int i = 0; i < 5; i++) run_move(i, 16'h2002, 16'h33F1);
        chk("B indx", 32'(indx), 32'd5);
        chk("B bad rdy", 32'(cmd_rdy), 32'd0);
        chk("B err pre", 32'(tour_err), 32'd0);
        step();
        chk("B err set", 32'(tour_err), 32'd1);
        chk("B idle", 32'(tour_busy), 32'd0);
        step();
        chk("B err sticky", 32'(tour_err), 32'd1);
        moves[5] = 8'h01;
        start_tour = 1'b1;
        step();
        start_tour = 1'b0;
        chk("C err clr", 32'(tour_err), 32'd0);
        chk("C indx", 32'(indx), 32'd0);
        chk("C rdy", 32'(cmd_rdy), 32'd1);

        // Tour C: reset in HOLDH at index 10, together with start_tour
        for (int i = 0; i < 10; i++) run_move(i, 16'h2002, 16'h33F1);
        handshake("C10 vert", 16'h2002, 0, 8'h5A);
        respond(0);
        handshake("C10 horz", 16'h33F1, 0, 8'h5A);
        chk("C holdh indx", 32'(indx), 32'd10);
        rst = 1'b1; start_tour = 1'b1; cmd_rdy_UART = 1'b1; cmd_UART = 16'hBEEF;
        step();
        rst = 1'b0; start_tour = 1'b0;
        chk("C rst busy", 32'(tour_busy), 32'd0);
        chk("C rst indx", 32'(indx), 32'd0);
        chk("C rst rdy", 32'(cmd_rdy), 32'd1);
        chk("C rst cmd", 32'(cmd), 32'hBEEF);
        step();
        chk("C rst wins", 32'(tour_busy), 32'd0);
        cmd_rdy_UART = 1'b0;
        #1;
        chk("C uart rdy low", 32'(cmd_rdy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
